ahb_lite_slave_xbar: RTL and testbench

- Parametrised AHB-Lite address decoder and slave multiplexer for one master and NUM_SLAVES slaves.
- Successor to the fixed two-slave dmem mux (UART + ROM).
- Per-slave base/mask decode, data-phase tracking, and a built-in default slave that returns the two-cycle AHB ERROR response for unmapped addresses.
- Sits between the core dmem AHB port and the SoC peripherals/memories.

---
 rtl/ahb_lite_slave_xbar_if.sv | 40 ++++
 rtl/ahb_lite_slave_xbar.sv | 216 +++++++++++++++++++++
 tb/tb_ahb_lite_slave_xbar.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_lite_slave_xbar_if.sv
// rtl/ahb_lite_slave_xbar_if.sv - bus bundle between the dmem AHB-Lite master, the xbar and its slaves
//
// Signals:
//   m_haddr, m_htrans              master address phase into the xbar
//   m_hready, m_hrdata, m_hresp    data-phase response back to the master (m_hready also feeds slave HREADY_IN)
//   s_hsel                         per-slave select, one-hot or zero
//   s_hreadyout, s_hresp, s_hrdata per-slave response, s_hrdata packed slave i at [i*DATA_W +: DATA_W]
//   timeout_irq, timeout_slave     slave timeout report
// Modports:
//   master  the surrounding system: core master plus attached slaves
//   slave   the crossbar itself
interface ahb_lite_slave_xbar_if #(
    parameter int NUM_SLAVES = 2,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
);
    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    logic [ADDR_W-1:0]            m_haddr;
    logic [1:0]                   m_htrans;
    logic                         m_hready;
    logic [DATA_W-1:0]            m_hrdata;
    logic                         m_hresp;
    logic [NUM_SLAVES-1:0]        s_hsel;
    logic [NUM_SLAVES-1:0]        s_hreadyout;
    logic [NUM_SLAVES-1:0]        s_hresp;
    logic [NUM_SLAVES*DATA_W-1:0] s_hrdata;
    logic                         timeout_irq;
    logic [IDX_W-1:0]             timeout_slave;

    modport master (
        output m_haddr, m_htrans, s_hreadyout, s_hresp, s_hrdata,
        input  m_hready, m_hrdata, m_hresp, s_hsel, timeout_irq, timeout_slave
    );

    modport slave (
        input  m_haddr, m_htrans, s_hreadyout, s_hresp, s_hrdata,
        output m_hready, m_hrdata, m_hresp, s_hsel, timeout_irq, timeout_slave
    );
endinterface

// File: rtl/ahb_lite_slave_xbar.sv
// rtl/ahb_lite_slave_xbar.sv - AHB-Lite address decoder and slave mux with built-in default slave
//
// Ports:
//   clk   system clock
//   rst   synchronous reset, active-high
//   bus   ahb_lite_slave_xbar_if.slave: master address/response, per-slave select/response, timeout report
// Optional feature macro: AHB_XBAR_TIMEOUT_EN (slave wait-state timeout with stall marking)
module ahb_lite_slave_xbar #(
    parameter int                             NUM_SLAVES     = 2,
    parameter int                             ADDR_W         = 32,
    parameter int                             DATA_W         = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0]   SLAVE_BASE     = {32'hFFEE0000, 32'hFFDF0000},
    parameter logic [NUM_SLAVES*ADDR_W-1:0]   SLAVE_MASK     = {32'hFFFE0000, 32'hFFFF0000},
    parameter int                             TIMEOUT_CYCLES = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    ahb_lite_slave_xbar_if.slave bus
);
    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    typedef enum logic [1:0] {
        DS_IDLE,
        DS_ERR1,
        DS_ERR2
    } ds_state_e;

    logic [NUM_SLAVES-1:0] hit;
    logic [NUM_SLAVES-1:0] eff_hit;
    logic [NUM_SLAVES-1:0] stall_mask;
    logic [NUM_SLAVES-1:0] hsel;
    logic [IDX_W-1:0]      win_idx;
    logic                  any_hit;

    logic                  dp_valid_q, dp_valid_d;
    logic                  dp_def_q, dp_def_d;
    logic [IDX_W-1:0]      dp_idx_q, dp_idx_d;
    ds_state_e             ds_q, ds_d;

    logic                  hready;
    logic                  hresp;
    logic [DATA_W-1:0]     hrdata;
    logic                  sel_hreadyout;
    logic                  def_accept;
    logic                  to_err1;
    logic                  to_err2;

    // Address decode. A stalled slave is treated as unmapped so the default slave answers for it.
    always_comb begin
        for (int i = 0; i < NUM_SLAVES; i++) begin
            hit[i] = ((bus.m_haddr & SLAVE_MASK[i*ADDR_W +: ADDR_W]) == SLAVE_BASE[i*ADDR_W +: ADDR_W]);
        end
    end

    assign eff_hit = hit & ~stall_mask;

    // Scan from the top down so the lowest matching index is the last one written and wins.
    always_comb begin
        win_idx = '0;
        any_hit = 1'b0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (eff_hit[i]) begin
                win_idx = IDX_W'(i);
                any_hit = 1'b1;
            end
        end
    end

    always_comb begin
        hsel = '0;
        if (any_hit) begin
            hsel[win_idx] = 1'b1;
        end
    end

    assign sel_hreadyout = bus.s_hreadyout[dp_idx_q];

    // Response mux for the transfer currently in its data phase.
    always_comb begin
        hready = 1'b1;
        hresp  = 1'b0;
        hrdata = '0;
        if (dp_valid_q) begin
            if (dp_def_q) begin
                hready = (ds_q != DS_ERR1);
                hresp  = 1'b1;
            end else if (to_err1) begin
                hready = 1'b0;
                hresp  = 1'b1;
            end else if (to_err2) begin
                hready = 1'b1;
                hresp  = 1'b1;
            end else begin
                hready = sel_hreadyout;
                hresp  = bus.s_hresp[dp_idx_q];
                hrdata = bus.s_hrdata[dp_idx_q*DATA_W +: DATA_W];
            end
        end
    end

    // Data-phase tracking: the address phase is accepted whenever HREADY is high.
    always_comb begin
        dp_valid_d = dp_valid_q;
        dp_def_d   = dp_def_q;
        dp_idx_d   = dp_idx_q;
        if (hready) begin
            dp_valid_d = bus.m_htrans[1];
            dp_idx_d   = win_idx;
            dp_def_d   = bus.m_htrans[1] & ~any_hit;
        end
    end

    assign def_accept = hready & bus.m_htrans[1] & ~any_hit;

    // Default slave: two-cycle ERROR; ERR2 can chain straight into another ERR1.
    always_comb begin
        ds_d = ds_q;
        case (ds_q)
            DS_IDLE: if (def_accept) ds_d = DS_ERR1;
            DS_ERR1: ds_d = DS_ERR2;
            DS_ERR2: ds_d = def_accept ? DS_ERR1 : DS_IDLE;
            default: ds_d = DS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dp_valid_q <= 1'b0;
            dp_def_q   <= 1'b0;
            dp_idx_q   <= '0;
            ds_q       <= DS_IDLE;
        end else begin
            dp_valid_q <= dp_valid_d;
            dp_def_q   <= dp_def_d;
            dp_idx_q   <= dp_idx_d;
            ds_q       <= ds_d;
        end
    end

`ifdef AHB_XBAR_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        TO_IDLE,
        TO_ERR1,
        TO_ERR2
    } to_state_e;

    to_state_e             to_q, to_d;
    logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;
    logic [NUM_SLAVES-1:0] stall_q, stall_d;
    logic [IDX_W-1:0]      to_slave_q, to_slave_d;
    logic                  waiting;

    always_comb begin
        to_d       = to_q;
        wait_cnt_d = wait_cnt_q;
        to_slave_d = to_slave_q;
        // A stall mark is dropped the first cycle that slave reports ready again.
        stall_d    = stall_q & ~bus.s_hreadyout;
        waiting    = dp_valid_q & ~dp_def_q & ~sel_hreadyout & (to_q == TO_IDLE);

        if (hready) begin
            wait_cnt_d = '0;
        end else if (waiting) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end else if (sel_hreadyout) begin
            wait_cnt_d = '0;
        end

        case (to_q)
            TO_IDLE: begin
                if (waiting && (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1))) begin
                    to_d              = TO_ERR1;
                    stall_d[dp_idx_q] = 1'b1;
                    to_slave_d        = dp_idx_q;
                end
            end
            TO_ERR1: to_d = TO_ERR2;
            TO_ERR2: to_d = TO_IDLE;
            default: to_d = TO_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            to_q       <= TO_IDLE;
            wait_cnt_q <= '0;
            stall_q    <= '0;
            to_slave_q <= '0;
        end else begin
            to_q       <= to_d;
            wait_cnt_q <= wait_cnt_d;
            stall_q    <= stall_d;
            to_slave_q <= to_slave_d;
        end
    end

    assign to_err1           = (to_q == TO_ERR1);
    assign to_err2           = (to_q == TO_ERR2);
    assign stall_mask        = stall_q;
    assign bus.timeout_irq   = to_err2;
    assign bus.timeout_slave = to_slave_q;
`else
    assign to_err1           = 1'b0;
    assign to_err2           = 1'b0;
    assign stall_mask        = '0;
    assign bus.timeout_irq   = 1'b0;
    assign bus.timeout_slave = '0;
`endif

    assign bus.s_hsel   = hsel;
    assign bus.m_hready = hready;
    assign bus.m_hresp  = hresp;
    assign bus.m_hrdata = hrdata;
endmodule

// File: tb/tb_ahb_lite_slave_xbar.sv
// tb/tb_ahb_lite_slave_xbar.sv - scoreboard bench for ahb_lite_slave_xbar
module tb_ahb_lite_slave_xbar;
    localparam int NS = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;
`ifdef AHB_XBAR_TIMEOUT_EN
    localparam int EXP_IRQ = 1;
    localparam int EXP_TS  = 1;
`else
    localparam int EXP_IRQ = 0;
    localparam int EXP_TS  = 0;
`endif

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  trans;
        int          waits;
        logic [31:0] data;
        logic        resp;
        int          op;
    } stim_t;

    typedef struct {
        int          waits;
        logic        resp;
        logic [31:0] data;
        bit          chk_data;
        bit          chk_wresp;
        logic        wresp;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ahb_lite_slave_xbar_if #(.NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW)) bus ();

    ahb_lite_slave_xbar #(
        .NUM_SLAVES    (NS),
        .ADDR_W        (AW),
        .DATA_W        (DW),
        .SLAVE_BASE    ({32'hFFEE0000, 32'hFFDF0000}),
        .SLAVE_MASK    ({32'hFFFE0000, 32'hFFFF0000}),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [31:0] mbase [NS] = '{32'hFFDF0000, 32'hFFEE0000};
    logic [31:0] mmask [NS] = '{32'hFFFF0000, 32'hFFFE0000};

    stim_t   stim_q[$];
    exp_t    exp_q[$];
    bit [NS-1:0] stuck     = '0;
    bit [NS-1:0] ref_stall = '0;
    bit      mon_en  = 1'b0;
    int      checks  = 0;
    int      failures = 0;
    int      irq_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode: first slave in index order whose masked address equals its base.
    function automatic int ref_decode(input logic [31:0] a);
        for (int i = 0; i < NS; i++) begin
            if (!ref_stall[i] && ((a & mmask[i]) == mbase[i])) return i;
        end
        return -1;
    endfunction

    task automatic add(input logic [31:0] a, input logic [1:0] t, input int w,
                       input logic [31:0] d, input logic r, input int op);
        stim_t s;
        s.addr = a; s.trans = t; s.waits = w; s.data = d; s.resp = r; s.op = op;
        stim_q.push_back(s);
    endtask

    task automatic apply_op(input int op);
        if (op == 1) stuck[1] = 1'b1;
        if (op == 2) stuck = '0;
    endtask

    task automatic run_driver();
        stim_t ap;
        exp_t  e;
        int    idx, dp_tgt, dp_left, dp_cycles;
        bit    dp_to, done;
        logic [31:0] dp_data;
        logic  dp_resp, hr;
        logic [NS-1:0] hrdy, hsp, eh;
        logic [NS*DW-1:0] rd;
        dp_tgt = -1; dp_left = 0; dp_cycles = 0; dp_to = 0; done = 0;
        dp_data = '0; dp_resp = 1'b0;
        ap = stim_q.pop_front();
        apply_op(ap.op);
        while (!done) begin
            for (int i = 0; i < NS; i++) begin
                hrdy[i] = stuck[i] ? 1'b0 : ($urandom_range(0, 3) != 0);
                hsp[i]  = 1'($urandom_range(0, 1));
                rd[i*DW +: DW] = $urandom;
            end
            if (dp_tgt >= 0) begin
                if (!dp_to) hrdy[dp_tgt] = (dp_left == 0);
                hsp[dp_tgt] = (!dp_to && dp_left == 0) ? dp_resp : 1'b0;
                rd[dp_tgt*DW +: DW] = dp_data;
            end
            bus.s_hreadyout = hrdy;
            bus.s_hresp     = hsp;
            bus.s_hrdata    = rd;
            bus.m_haddr     = ap.addr;
            bus.m_htrans    = ap.trans;
            @(negedge clk);
            idx = ref_decode(ap.addr);
            eh = '0;
            if (idx >= 0) eh[idx] = 1'b1;
            check("s_hsel", bus.s_hsel, eh);
            hr = bus.m_hready;
            @(posedge clk);
            #1;
            if (hr) begin
                e.waits = 0; e.resp = 1'b0; e.data = '0; e.chk_data = 1; e.chk_wresp = 0; e.wresp = 1'b0;
                dp_tgt = -1; dp_to = 0; dp_left = 0;
                if (ap.trans[1]) begin
                    if (idx < 0) begin
                        e.waits = 1; e.resp = 1'b1; e.chk_data = 0; e.chk_wresp = 1; e.wresp = 1'b1;
                    end else if (stuck[idx]) begin
                        e.waits = TO + 1; e.resp = 1'b1; e.chk_data = 0; e.chk_wresp = 1; e.wresp = 1'b1;
                        dp_tgt = idx; dp_to = 1;
                    end else begin
                        e.waits = ap.waits; e.resp = ap.resp; e.data = ap.data;
                        e.chk_wresp = (ap.waits > 0);
                        dp_tgt = idx; dp_left = ap.waits; dp_data = ap.data; dp_resp = ap.resp;
                    end
                end
                exp_q.push_back(e);
                dp_cycles = 0;
                if (stim_q.size() == 0) done = 1;
                else begin
                    ap = stim_q.pop_front();
                    apply_op(ap.op);
                end
            end else begin
                dp_cycles++;
                if (dp_tgt >= 0 && dp_left > 0) dp_left--;
            end
            for (int i = 0; i < NS; i++) if (hrdy[i]) ref_stall[i] = 1'b0;
            if (!hr && dp_to && dp_cycles == TO) ref_stall[dp_tgt] = 1'b1;
        end
    endtask

    // Monitor: every HREADY-high cycle closes one data phase.
    initial begin
        int   wcnt;
        logic wresp;
        exp_t e;
        wcnt = 0; wresp = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (!bus.m_hready) begin
                    wcnt++;
                    wresp = bus.m_hresp;
                end else if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_completion actual=1 required=0 at %0t", $time);
                    wcnt = 0;
                end else begin
                    e = exp_q.pop_front();
                    check("wait_cycles", wcnt, e.waits);
                    check("m_hresp", bus.m_hresp, e.resp);
                    if (e.chk_data) check("m_hrdata", bus.m_hrdata, e.data);
                    if (e.chk_wresp) check("wait_hresp", wresp, e.wresp);
                    wcnt = 0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.timeout_irq) irq_cnt++;
        end
    end

    initial begin
        repeat (50000) @(posedge clk);
        checks++;
        failures++;
        $display("FAIL watchdog actual=expired required=done");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        exp_t e0;
        int   kind;
        logic [31:0] a;
        bus.m_haddr = '0; bus.m_htrans = 2'b00;
        bus.s_hreadyout = '1; bus.s_hresp = '0; bus.s_hrdata = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_m_hready", bus.m_hready, 1);
        check("rst_m_hresp", bus.m_hresp, 0);
        check("rst_m_hrdata", bus.m_hrdata, 0);
        check("rst_s_hsel", bus.s_hsel, 0);
        check("rst_timeout_irq", bus.timeout_irq, 0);
        check("rst_timeout_slave", bus.timeout_slave, 0);

        add(32'hFFDF0004, 2'b10, 2, 32'h000000A5, 1'b0, 0);
        add(32'hFFEE0000, 2'b10, 0, 32'h11112222, 1'b0, 0);
        add(32'hFFDF0000, 2'b10, 0, 32'h33334444, 1'b0, 0);
        add(32'h80000000, 2'b10, 0, 32'h0, 1'b0, 0);
        add(32'h00000000, 2'b00, 0, 32'h0, 1'b0, 0);
        add(32'hFFEE0000, 2'b01, 0, 32'h0, 1'b0, 0);
        add(32'h80000000, 2'b10, 0, 32'h0, 1'b0, 0);
        add(32'h80000010, 2'b11, 0, 32'h0, 1'b0, 0);
        add(32'hFFEE0008, 2'b11, 3, 32'hCAFEF00D, 1'b0, 0);
        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 3);
            case (kind)
                0:       a = 32'hFFDF0000 | ($urandom & 32'h0000FFFC);
                1:       a = 32'hFFEE0000 | ($urandom & 32'h0001FFFC);
                2:       a = $urandom & 32'h7FFFFFFC;
                default: a = $urandom;
            endcase
            add(a, ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3)),
                $urandom_range(0, 3), $urandom, ($urandom_range(0, 7) == 0), 0);
        end
`ifdef AHB_XBAR_TIMEOUT_EN
        add(32'hFFEE0010, 2'b10, 0, 32'h0, 1'b0, 1);
        add(32'hFFEE0000, 2'b10, 0, 32'h0, 1'b0, 0);
        add(32'h00000000, 2'b00, 0, 32'h0, 1'b0, 2);
        for (int n = 0; n < 4; n++) add(32'h00000000, 2'b00, 0, 32'h0, 1'b0, 0);
        add(32'hFFEE0004, 2'b10, 1, 32'h5A5A1234, 1'b0, 0);
        add(32'hFFDF0008, 2'b10, 0, 32'h87654321, 1'b0, 0);
`endif
        add(32'h00000000, 2'b00, 0, 32'h0, 1'b0, 0);

        @(posedge clk);
        #1;
        rst = 1'b0;
        e0.waits = 0; e0.resp = 1'b0; e0.data = '0; e0.chk_data = 1; e0.chk_wresp = 0; e0.wresp = 1'b0;
        exp_q.push_back(e0);
        mon_en = 1'b1;
        run_driver();
        @(negedge clk);
        #1;
        check("exp_queue_drained", exp_q.size(), 0);
        mon_en = 1'b0;
        check("timeout_irq_pulses", irq_cnt, EXP_IRQ);
        check("timeout_slave", bus.timeout_slave, EXP_TS);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
